// File: rtl/qu_uop_dispatch.sv
// rtl/qu_uop_dispatch.sv - in-order uop dispatch FIFO routing the head to the int/ctrl or ld/st port
// Optional macro QU_UOP_DISPATCH_ILLEGAL_TRAP_EN: an illegal head stalls the queue instead of being discarded.
module qu_uop_dispatch #(
    parameter int DEPTH     = 4,
    parameter int UOP_WIDTH = 67
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [UOP_WIDTH-1:0]         in_uop_i,
    output logic                         ic_valid_o,
    input  logic                         ic_ready_i,
    output logic [UOP_WIDTH-1:0]         ic_uop_o,
    output logic                         ldst_valid_o,
    input  logic                         ldst_ready_i,
    output logic [UOP_WIDTH-1:0]         ldst_uop_o,
    output logic                         illegal_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [UOP_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_count;

    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_discard;
    logic [UOP_WIDTH-1:0] w_head;
    logic [2:0]           w_optype;

    assign w_empty  = (r_count == '0);
    assign w_head   = r_mem[r_rd_ptr];
    assign w_optype = w_head[2:0];

    // Legal codes all have bit 0 set; bit 2 separates int/ctrl from load/store.
    assign ic_valid_o   = !w_empty &&  w_optype[0] && !w_optype[2];
    assign ldst_valid_o = !w_empty &&  w_optype[0] &&  w_optype[2];
    assign illegal_o    = !w_empty && !w_optype[0];

    assign ic_uop_o    = w_head;
    assign ldst_uop_o  = w_head;
    assign in_ready_o  = (r_count != CW'(DEPTH));
    assign occupancy_o = r_count;

`ifdef QU_UOP_DISPATCH_ILLEGAL_TRAP_EN
    assign w_discard = 1'b0;
`else
    assign w_discard = illegal_o;
`endif

    assign w_push = in_valid_i && in_ready_o && !flush_i;
    assign w_pop  = (ic_valid_o && ic_ready_i) || (ldst_valid_o && ldst_ready_i) || w_discard;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_uop_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_qu_uop_dispatch.sv
// tb/tb_qu_uop_dispatch.sv - directed vector bench for qu_uop_dispatch
module tb_qu_uop_dispatch;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [66:0] in_uop_i;
    logic        ic_valid_o;
    logic        ic_ready_i;
    logic [66:0] ic_uop_o;
    logic        ldst_valid_o;
    logic        ldst_ready_i;
    logic [66:0] ldst_uop_o;
    logic        illegal_o;
    logic [2:0]  occupancy_o;

    qu_uop_dispatch #(.DEPTH(4), .UOP_WIDTH(67)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_uop_i     (in_uop_i),
        .ic_valid_o   (ic_valid_o),
        .ic_ready_i   (ic_ready_i),
        .ic_uop_o     (ic_uop_o),
        .ldst_valid_o (ldst_valid_o),
        .ldst_ready_i (ldst_ready_i),
        .ldst_uop_o   (ldst_uop_o),
        .illegal_o    (illegal_o),
        .occupancy_o  (occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        vin;
        logic [66:0] uop;
        logic        icr;
        logic        lsr;
        logic        e_inr;
        logic        e_ic;
        logic        e_ls;
        logic        e_ill;
        logic [2:0]  e_occ;
        logic [66:0] e_uop;
    } vec_t;

    vec_t tbl[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic logic [66:0] mk(input logic [2:0] op, input logic [7:0] tag);
        return {tag, 56'h3C96A50F1E2D4B ^ {tag, 48'h0}, op};
    endfunction

    task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic fl, input logic vin, input logic [66:0] u,
                       input logic icr, input logic lsr,
                       input logic inr, input logic ic, input logic ls, input logic ill,
                       input logic [2:0] occ, input logic [66:0] eu);
        vec_t v;
        v.fl = fl; v.vin = vin; v.uop = u; v.icr = icr; v.lsr = lsr;
        v.e_inr = inr; v.e_ic = ic; v.e_ls = ls; v.e_ill = ill; v.e_occ = occ; v.e_uop = eu;
        tbl.push_back(v);
    endtask

    // Called at posedge+1: drive, check at negedge, return at next posedge+1.
    task automatic run_row(input int idx, input vec_t v);
        flush_i      = v.fl;
        in_valid_i   = v.vin;
        in_uop_i     = v.uop;
        ic_ready_i   = v.icr;
        ldst_ready_i = v.lsr;
        @(negedge clk);
        chk($sformatf("r%0d_in_ready", idx), 67'(in_ready_o),   67'(v.e_inr));
        chk($sformatf("r%0d_ic_valid", idx), 67'(ic_valid_o),   67'(v.e_ic));
        chk($sformatf("r%0d_ls_valid", idx), 67'(ldst_valid_o), 67'(v.e_ls));
        chk($sformatf("r%0d_illegal",  idx), 67'(illegal_o),    67'(v.e_ill));
        chk($sformatf("r%0d_occ",      idx), 67'(occupancy_o),  67'(v.e_occ));
        if (v.e_ic || v.e_ls || v.e_ill) begin
            chk($sformatf("r%0d_ic_uop", idx), ic_uop_o,   v.e_uop);
            chk($sformatf("r%0d_ls_uop", idx), ldst_uop_o, v.e_uop);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [66:0] z;
        z = '0;
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_uop_i = '0;
        ic_ready_i = 1'b0; ldst_ready_i = 1'b0;

        // Basic routing, back to back
        add(0,1,mk(1,1),1,1, 1,0,0,0,0,z);
        add(0,1,mk(3,2),1,1, 1,1,0,0,1,mk(1,1));
        add(0,1,mk(5,3),1,1, 1,1,0,0,1,mk(3,2));
        add(0,1,mk(7,4),1,1, 1,0,1,0,1,mk(5,3));
        add(0,0,z,      1,1, 1,0,1,0,1,mk(7,4));
        add(0,0,z,      1,1, 1,0,0,0,0,z);
        // Full and backpressure, then drain with pointer wrap
        add(0,1,mk(1,16),0,0, 1,0,0,0,0,z);
        add(0,1,mk(3,17),0,0, 1,1,0,0,1,mk(1,16));
        add(0,1,mk(1,18),0,0, 1,1,0,0,2,mk(1,16));
        add(0,1,mk(3,19),0,0, 1,1,0,0,3,mk(1,16));
        add(0,1,mk(1,20),0,0, 0,1,0,0,4,mk(1,16));
        add(0,1,mk(1,20),1,0, 0,1,0,0,4,mk(1,16));
        add(0,1,mk(1,20),1,0, 1,1,0,0,3,mk(3,17));
        add(0,1,mk(3,21),1,0, 1,1,0,0,3,mk(1,18));
        add(0,0,z,       1,0, 1,1,0,0,3,mk(3,19));
        add(0,0,z,       1,0, 1,1,0,0,2,mk(1,20));
        add(0,0,z,       1,0, 1,1,0,0,1,mk(3,21));
        add(0,0,z,       1,0, 1,0,0,0,0,z);
        // Head-of-line blocking
        add(0,1,mk(5,32),1,0, 1,0,0,0,0,z);
        add(0,1,mk(1,33),1,0, 1,0,1,0,1,mk(5,32));
        add(0,0,z,       1,0, 1,0,1,0,2,mk(5,32));
        add(0,0,z,       1,1, 1,0,1,0,2,mk(5,32));
        add(0,0,z,       1,1, 1,1,0,0,1,mk(1,33));
        add(0,0,z,       1,1, 1,0,0,0,0,z);
        // Flush with a simultaneous push
        add(0,1,mk(1,48),0,0, 1,0,0,0,0,z);
        add(0,1,mk(5,49),0,0, 1,1,0,0,1,mk(1,48));
        add(0,1,mk(3,50),0,0, 1,1,0,0,2,mk(1,48));
        add(1,1,mk(7,51),0,0, 1,1,0,0,3,mk(1,48));
        add(0,0,z,       1,1, 1,0,0,0,0,z);
        add(0,1,mk(1,52),1,1, 1,0,0,0,0,z);
        add(0,0,z,       1,1, 1,1,0,0,1,mk(1,52));
        add(0,0,z,       1,1, 1,0,0,0,0,z);
        // Illegal optype between two INTs
        add(0,1,mk(1,64),1,1, 1,0,0,0,0,z);
        add(0,1,mk(2,65),1,1, 1,1,0,0,1,mk(1,64));
`ifdef QU_UOP_DISPATCH_ILLEGAL_TRAP_EN
        add(0,1,mk(3,66),1,1, 1,0,0,1,1,mk(2,65));
        add(0,0,z,       1,1, 1,0,0,1,2,mk(2,65));
        add(0,0,z,       1,1, 1,0,0,1,2,mk(2,65));
        add(1,0,z,       1,1, 1,0,0,1,2,mk(2,65));
        add(0,0,z,       1,1, 1,0,0,0,0,z);
`else
        add(0,1,mk(3,66),1,1, 1,0,0,1,1,mk(2,65));
        add(0,0,z,       1,1, 1,1,0,0,1,mk(3,66));
        add(0,0,z,       1,1, 1,0,0,0,0,z);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 67'(in_ready_o),   67'(1));
        chk("reset_ic_valid", 67'(ic_valid_o),   67'(0));
        chk("reset_ls_valid", 67'(ldst_valid_o), 67'(0));
        chk("reset_illegal",  67'(illegal_o),    67'(0));
        chk("reset_occ",      67'(occupancy_o),  67'(0));
        rst = 1'b0;

        foreach (tbl[i]) run_row(i, tbl[i]);

        // Async reset mid-stream, away from the clock edge
        flush_i = 1'b0; ic_ready_i = 1'b0; ldst_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid_i = 1'b1;
            in_uop_i   = mk(5, 8'(80 + k));
            @(posedge clk);
            #1;
        end
        in_valid_i = 1'b0;
        #5;
        chk("arst_pre_occ",      67'(occupancy_o),  67'(3));
        chk("arst_pre_ls_valid", 67'(ldst_valid_o), 67'(1));
        chk("arst_pre_uop",      ldst_uop_o,        mk(5,80));
        #1;
        rst = 1'b1;
        #1;
        chk("arst_occ",      67'(occupancy_o),  67'(0));
        chk("arst_in_ready", 67'(in_ready_o),   67'(1));
        chk("arst_ic_valid", 67'(ic_valid_o),   67'(0));
        chk("arst_ls_valid", 67'(ldst_valid_o), 67'(0));
        chk("arst_illegal",  67'(illegal_o),    67'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("arst_post_occ", 67'(occupancy_o), 67'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/qu_uop_dispatch.md
# qu_uop_dispatch

In-order micro-op dispatch buffer sitting between the decode/rename stage (producer of `qu_uop::uop_t`) and the execution back end. It buffers up to `DEPTH` 67-bit uops in a FIFO, inspects the head's `optype`, and routes it over a valid/ready handshake. Integer and control uops go to the integer/control issue port; load and store uops go to the load/store port. Uops with an illegal `optype` are discarded or trapped, depending on configuration.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `UOP_WIDTH`, `qu_uop::UOP_WIDTH` (67): uop width.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `flush_i`, input, 1: synchronous flush; empties the FIFO.
- `in_valid_i`, input, 1: upstream uop valid.
- `in_ready_o`, output, 1: FIFO can accept.
- `in_uop_i`, input, UOP_WIDTH: incoming `uop_t`.
- `ic_valid_o`, output, 1: head is `OPTYPE_INT` or `OPTYPE_CONT`.
- `ic_ready_i`, input, 1: integer/control port ready.
- `ic_uop_o`, output, UOP_WIDTH: head uop (`uop_ic_t` view).
- `ldst_valid_o`, output, 1: head is `OPTYPE_LOAD` or `OPTYPE_STORE`.
- `ldst_ready_i`, input, 1: load/store port ready.
- `ldst_uop_o`, output, UOP_WIDTH: head uop (`uop_ldst_t` view).
- `illegal_o`, output, 1: head `optype` is not one of the four legal codes.
- `occupancy_o`, output, $clog2(DEPTH+1): number of valid entries.

## Operation
- FIFO: circular buffer with read pointer, write pointer and count. Pointers are $clog2(DEPTH) bits and wrap modulo `DEPTH`.
- Push condition: `in_valid_i && in_ready_o && !flush_i`.
- `in_ready_o = (count != DEPTH)`. There is no same-cycle pass-through when full: a pop while full does not raise `in_ready_o` in that cycle.
- Head decode uses `optype = head[2:0]`:
  - 001 or 011 selects the integer/control port.
  - 101 or 111 selects the load/store port.
  - All other codes (LSB 0) are illegal.
- Only the head is examined, strictly in order. A stalled head blocks younger uops even when those target the other, ready port.
- `ic_uop_o` and `ldst_uop_o` both carry the head's bits unmodified. Each is meaningful only while its valid is high.
- Pop condition: `(ic_valid_o && ic_ready_i) || (ldst_valid_o && ldst_ready_i)`, or an illegal head being discarded (see Configuration).
- At most one uop pops per cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Flush: on `flush_i`, count and both pointers go to 0 at the next edge. Flush overrides any push or pop in the same cycle, and the beat offered on `in_uop_i` is dropped. Dispatch handshakes that complete in the flush cycle are still valid to downstream.
- Reset mid-operation: all state clears immediately (asynchronous) and buffered uops are lost.
- Reset values: `in_ready_o = 1`; `ic_valid_o`, `ldst_valid_o`, `illegal_o` = 0; `occupancy_o` = 0. The uop outputs are don't-care while the corresponding valid is low.

## Timing
- Latency: a uop accepted at edge N is at the head and its valid is visible in the cycle after edge N, provided the FIFO was empty. Minimum latency is 1 cycle.
- Throughput: 1 uop/cycle in steady state when downstream is ready.
- `ic_valid_o`, `ldst_valid_o` and `illegal_o` are combinational from FIFO state only, with no dependence on `*_ready_i`. They are mutually exclusive and are all 0 when the FIFO is empty.
- Once a valid is asserted, it and its uop stay stable until the handshake completes, unless `flush_i` or `rst` intervenes.
- `occupancy_o` is registered and reflects the count after the most recent edge.

## Configuration
- Macro: `QU_UOP_DISPATCH_ILLEGAL_TRAP_EN`.
- Defined (trap mode):
  - An illegal head is never popped. `illegal_o` stays high and the FIFO stalls until `flush_i` or `rst`.
  - Pushes continue while space remains.
- Undefined (discard mode):
  - An illegal head is popped in the cycle it reaches the head. `illegal_o` is high for exactly that one cycle per illegal uop.
  - The next uop reaches the head in the following cycle.

## Test plan
- Basic routing: push uops with `optype` 001, 011, 101, 111 back to back, both readies held at 1. Expect `ic_valid_o`, `ic_valid_o`, `ldst_valid_o`, `ldst_valid_o` on consecutive cycles starting 1 cycle after the first push, with uops bit-exact.
- Full/backpressure with `DEPTH = 4`: hold both readies at 0 and push 6 uops. Expect `in_ready_o` = 0 after 4 accepted and `occupancy_o` = 4. Then set `ic_ready_i` = 1 (all INT): expect 1 pop/cycle and the remaining 2 uops accepted in order, with the pointers wrapping correctly.
- Head-of-line blocking: queue LOAD then INT with `ldst_ready_i` = 0 and `ic_ready_i` = 1. Expect no `ic_valid_o` until `ldst_ready_i` rises, after which INT dispatches on the next cycle.
- Flush: with 3 entries queued, assert `flush_i` together with a push. Expect `occupancy_o` = 0 and all valids 0 the next cycle, and the pushed uop is not present.
- Illegal optype 010 between two INTs:
  - Without the macro: expect a 1-cycle `illegal_o` pulse and both INTs dispatched.
  - With the macro: expect `illegal_o` held high, the second INT not dispatched, and both cleared by `flush_i`.
- Async reset: assert `rst` mid-stream, away from any clock edge. Expect `occupancy_o` = 0, `in_ready_o` = 1 and valids = 0 immediately, before the next edge.
